// File: rtl/mixer_pkg.sv
// Shared widths, Q1.15 scaling and saturation limits for the LO mixer.
package mixer_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int PROD_W    = 32;
  localparam int Q15_SHIFT = 15;
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  // Clamp a 17-bit scaled result into the 16-bit output range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(
    input logic signed [PROD_W-Q15_SHIFT-1:0] v);
    if (int'(v) > SAT_MAX) return SAMPLE_W'(SAT_MAX);
    if (int'(v) < SAT_MIN) return SAMPLE_W'(SAT_MIN);
    return SAMPLE_W'(v);
  endfunction
endpackage

// File: rtl/mul16s_pipe.sv
// Signed 16x16->32 multiplier with a single registered output stage.
module mul16s_pipe
  import mixer_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic signed [SAMPLE_W-1:0] i_a,
  input  logic signed [SAMPLE_W-1:0] i_b,
  output logic signed [PROD_W-1:0]   o_p
);
  logic signed [PROD_W-1:0] r_p;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) r_p <= '0;
    else       r_p <= PROD_W'(i_a) * PROD_W'(i_b);
  end

  assign o_p = r_p;
endmodule

// File: rtl/lo_mixer.sv
// Mixes audio with the LO, integrates 2**DECIM_LOG2 products and emits a decimated result.
// Define LO_MIXER_SAT_EN to clamp the result; otherwise out-of-range results wrap.
module lo_mixer
  import mixer_pkg::*;
#(
  parameter int DECIM_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] lo_in,
  input  logic                clr,
  output logic [SAMPLE_W-1:0] mix_out,
  output logic                mix_valid,
  input  logic                mix_ready,
  output logic                overrun
);
  localparam int P_W   = PROD_W - Q15_SHIFT;
  localparam int ACC_W = P_W + DECIM_LOG2;

  logic signed [SAMPLE_W-1:0] r_smp, r_lo;
  logic [1:0]                 r_vld_pipe;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [P_W-1:0]      w_p17;
  logic signed [ACC_W-1:0]    r_acc, w_sum;
  logic [DECIM_LOG2-1:0]      r_cnt;
  logic                       w_last;
  logic signed [P_W-1:0]      w_res17;
  logic signed [SAMPLE_W-1:0] w_res16;
  logic                       r_dump;
  logic signed [SAMPLE_W-1:0] r_dump_val;
  logic [SAMPLE_W-1:0]        r_mix_out;
  logic                       r_mix_valid, r_overrun;

  mul16s_pipe u_mul (
    .CLK  (CLK),
    .RSTb (RSTb),
    .i_a  (r_smp),
    .i_b  (r_lo),
    .o_p  (w_prod)
  );

  assign w_p17   = P_W'(w_prod >>> Q15_SHIFT);
  assign w_sum   = r_acc + {{DECIM_LOG2{w_p17[P_W-1]}}, w_p17};
  assign w_last  = r_vld_pipe[1] && (r_cnt == '1);
  // Dropping the low bits of the sum is the flooring arithmetic shift.
  assign w_res17 = w_sum[ACC_W-1:DECIM_LOG2];
`ifdef LO_MIXER_SAT_EN
  assign w_res16 = sat16(w_res17);
`else
  assign w_res16 = SAMPLE_W'(w_res17);
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_smp      <= '0;
      r_lo       <= '0;
      r_vld_pipe <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_dump     <= 1'b0;
      r_dump_val <= '0;
    end else if (clr) begin
      r_vld_pipe <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_dump     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], sample_valid};
      if (sample_valid) begin
        r_smp <= $signed(sample_in);
        r_lo  <= $signed(lo_in);
      end
      r_dump <= w_last;
      if (r_vld_pipe[1]) begin
        r_cnt <= r_cnt + 1'b1;
        // The last product goes into the dump value, so the next frame starts clean.
        r_acc <= w_last ? '0 : w_sum;
      end
      if (w_last) r_dump_val <= w_res16;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_dump && !clr) begin
        if (r_mix_valid && !mix_ready) r_overrun <= 1'b1;
        else begin
          r_mix_out   <= r_dump_val;
          r_mix_valid <= 1'b1;
        end
      end else if (r_mix_valid && mix_ready) begin
        r_mix_valid <= 1'b0;
      end
      if (clr) r_overrun <= 1'b0;
    end
  end

  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_lo_mixer.sv
// Scoreboard bench for lo_mixer at DECIM_LOG2=2.
module tb_lo_mixer;
  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] lo_in = '0;
  logic        clr = 1'b0;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        mix_ready = 1'b1;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] sbq[$];

  lo_mixer #(.DECIM_LOG2(2)) dut (
    .CLK(CLK), .RSTb(RSTb), .sample_in(sample_in), .sample_valid(sample_valid),
    .lo_in(lo_in), .clr(clr), .mix_out(mix_out), .mix_valid(mix_valid),
    .mix_ready(mix_ready), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  function automatic logic signed [15:0] mdl(input int s[4], input int l[4]);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += (s[i] * l[i]) >>> 15;
    acc = acc >>> 2;
`ifdef LO_MIXER_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return 16'(acc);
  endfunction

  function automatic logic signed [15:0] pop_exp();
    if (sbq.size() == 0) return 16'sh7abc;
    return sbq.pop_front();
  endfunction

  task automatic send(input int s, input int l);
    @(negedge CLK);
    sample_in = 16'(s); lo_in = 16'(l); sample_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge CLK); sample_valid = 1'b0; end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (mix_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", mix_valid); end
    checks++; if (mix_out !== 16'd0) begin errors++; $display("FAIL rst_out got %0d exp 0", mix_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    @(negedge CLK); RSTb = 1'b1;
  endtask

  task automatic test_const();
    int lat;
    logic signed [15:0] e;
    mix_ready = 1'b1;
    sbq.push_back(16'sd16383);
    repeat (4) send(16384, 32767);
    lat = 0;
    for (int k = 1; k <= 7 && lat == 0; k++) begin
      @(negedge CLK); sample_valid = 1'b0;
      if (mix_valid === 1'b1) lat = k;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL const_latency got %0d exp 4", lat); end
    e = pop_exp();
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL const_out got %0d exp %0d", $signed(mix_out), e); end
    @(negedge CLK);
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL const_pulse got %b exp 0", mix_valid); end
  endtask

  task automatic test_sat();
    bit ok;
    logic signed [15:0] e;
`ifdef LO_MIXER_SAT_EN
    sbq.push_back(16'sd32767);
`else
    sbq.push_back(-16'sd32768);
`endif
    repeat (4) send(-32768, -32768);
    idle(1);
    wait_valid(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got 0 exp 1"); end
    e = pop_exp();
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL sat_out got %0d exp %0d", $signed(mix_out), e); end
    @(negedge CLK);
  endtask

  task automatic test_alt_gaps();
    bit ok;
    logic signed [15:0] e;
    sbq.push_back(-16'sd1);
    for (int i = 0; i < 4; i++) begin
      send(1000, (i % 2 == 0) ? 32767 : -32767);
      idle(1 + (i % 2));
    end
    wait_valid(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alt_timeout got 0 exp 1"); end
    e = pop_exp();
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL alt_out got %0d exp %0d", $signed(mix_out), e); end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    logic signed [15:0] e;
    mix_ready = 1'b0;
    sbq.push_back(16'sd16383);
    repeat (8) send(16384, 32767);
    idle(8);
    e = pop_exp();
    checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", mix_valid); end
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL bp_hold got %0d exp %0d", $signed(mix_out), e); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", overrun); end
    @(negedge CLK); clr = 1'b1;
    @(negedge CLK); clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %b exp 0", overrun); end
    checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL clr_valid got %b exp 1", mix_valid); end
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL clr_out got %0d exp %0d", $signed(mix_out), e); end
    mix_ready = 1'b1;
    @(negedge CLK);
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", mix_valid); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic signed [15:0] e;
    mix_ready = 1'b1;
    repeat (2) send(32767, 32767);
    idle(3);
    #2 RSTb = 1'b0;
    #1;
    checks++; if (mix_valid !== 1'b0 || overrun !== 1'b0 || mix_out !== 16'd0) begin
      errors++; $display("FAIL midrst_state got %b/%b/%0d exp 0/0/0", mix_valid, overrun, mix_out);
    end
    @(negedge CLK); RSTb = 1'b1;
    sbq.push_back(16'sd8191);
    repeat (4) send(8192, 32767);
    idle(1);
    wait_valid(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got 0 exp 1"); end
    e = pop_exp();
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL midrst_out got %0d exp %0d", $signed(mix_out), e); end
    wait_valid(8, ok);
    checks++; if (ok) begin errors++; $display("FAIL midrst_extra got 1 exp 0"); end
  endtask

  task automatic test_simul_dump_accept();
    bit ok;
    logic signed [15:0] e;
    mix_ready = 1'b0;
    sbq.push_back(16'sd16383);
    sbq.push_back(16'sd8191);
    repeat (4) send(16384, 32767);
    idle(1);
    wait_valid(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_timeout got 0 exp 1"); end
    e = pop_exp();
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL sim_first got %0d exp %0d", $signed(mix_out), e); end
    repeat (4) send(8192, 32767);
    idle(2);
    @(negedge CLK); mix_ready = 1'b1;
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL sim_held got %0d exp %0d", $signed(mix_out), e); end
    @(negedge CLK);
    e = pop_exp();
    checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b exp 1", mix_valid); end
    checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL sim_new got %0d exp %0d", $signed(mix_out), e); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_overrun got %b exp 0", overrun); end
    @(negedge CLK);
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL sim_drain got %b exp 0", mix_valid); end
  endtask

  task automatic test_back_to_back();
    int s[5][4];
    int l[5][4];
    mix_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) begin
        s[f][i] = int'($signed(16'($urandom_range(0, 65535))));
        l[f][i] = int'($signed(16'($urandom_range(0, 65535))));
      end
      sbq.push_back(mdl(s[f], l[f]));
    end
    fork
      begin
        for (int f = 0; f < 5; f++)
          for (int i = 0; i < 4; i++) send(s[f][i], l[f][i]);
        idle(1);
      end
      begin
        bit ok;
        logic signed [15:0] e;
        for (int n = 0; n < 5; n++) begin
          wait_valid(12, ok);
          checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout frame %0d got 0 exp 1", n); end
          e = pop_exp();
          checks++; if ($signed(mix_out) !== e) begin errors++; $display("FAIL b2b_out frame %0d got %0d exp %0d", n, $signed(mix_out), e); end
        end
      end
    join
    idle(2);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_const();
    test_sat();
    test_alt_gaps();
    test_backpressure();
    test_reset_midframe();
    test_simul_dump_accept();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang exp finish");
    $fatal(1);
  end
endmodule
